// File: rtl/serial_in_parallel_out_sipo_16_bit.sv
// Serial-in parallel-out deserializer with a valid/ack holding register.
// Receive-side partner of the PISO shifter: one bit per shift strobe.
module serial_in_parallel_out_sipo_16_bit #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                          Clk_In,
  input  logic                          Reset_In,
  input  logic                          Enable_In,
  input  logic                          Serial_Data_In,
  input  logic                          Shift_Data_Signal_In,
  input  logic                          Clear_Signal_In,
  input  logic                          Data_Ack_In,
  output logic [DATA_WIDTH-1:0]         Parallel_Data_Out,
  output logic                          Data_Valid_Out,
  output logic                          Overrun_Out,
  output logic [$clog2(DATA_WIDTH)-1:0] Bit_Count_Out
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  logic [DATA_WIDTH-1:0] assembled;
  logic                  complete;

  // Next-state: clear beats strobe; ack is resolved alongside word completion.
  always_comb begin
    shift_d  = shift_q;
    hold_d   = hold_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    complete = 1'b0;

    if (MSB_FIRST) begin
      assembled = {shift_q[DATA_WIDTH-2:0], Serial_Data_In};
    end else begin
      assembled = {Serial_Data_In, shift_q[DATA_WIDTH-1:1]};
    end

    if (Clear_Signal_In) begin
      shift_d = '0;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (Shift_Data_Signal_In) begin
      shift_d = assembled;
      if (cnt_q == LAST_CNT) begin
        cnt_d    = '0;
        hold_d   = assembled;
        complete = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (complete) begin
      valid_d = 1'b1;
      if (valid_q && !Data_Ack_In) begin
        ovr_d = 1'b1;
      end
    end else if (Data_Ack_In) begin
      valid_d = 1'b0;
    end
  end

  // State registers: synchronous reset, frozen while disabled.
  always_ff @(posedge Clk_In) begin
    if (!Reset_In) begin
      shift_q <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (Enable_In) begin
      shift_q <= shift_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  // Output gating: data floats and valid drops while the block is disabled.
  assign Parallel_Data_Out = Enable_In ? hold_q : {DATA_WIDTH{1'bz}};
  assign Data_Valid_Out    = Enable_In & valid_q;
  assign Overrun_Out       = ovr_q;
  assign Bit_Count_Out     = cnt_q;

endmodule

// File: tb/tb_serial_in_parallel_out_sipo_16_bit.sv
// Bench for the SIPO deserializer: MSB-first and LSB-first instances share inputs.
module tb_serial_in_parallel_out_sipo_16_bit;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst, en, sd, sh, clr, ack;

  logic [W-1:0] pdo_m, pdo_l;
  logic         v_m, v_l, o_m, o_l;
  logic [3:0]   cnt_m, cnt_l;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bits of the current partial word, plus held words.
  bit           mq[$];
  logic [W-1:0] m_hold_m, m_hold_l;
  bit           m_valid, m_ovr;

  typedef struct {
    logic r, e, s, h, c, a;
    logic [3:0] cnt;
    logic v;
    logic o;
  } vec_t;
  vec_t tbl[8];

  always #5 clk = ~clk;

  serial_in_parallel_out_sipo_16_bit #(.DATA_WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Serial_Data_In(sd),
    .Shift_Data_Signal_In(sh), .Clear_Signal_In(clr), .Data_Ack_In(ack),
    .Parallel_Data_Out(pdo_m), .Data_Valid_Out(v_m), .Overrun_Out(o_m),
    .Bit_Count_Out(cnt_m));

  serial_in_parallel_out_sipo_16_bit #(.DATA_WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .Clk_In(clk), .Reset_In(rst), .Enable_In(en), .Serial_Data_In(sd),
    .Shift_Data_Signal_In(sh), .Clear_Signal_In(clr), .Data_Ack_In(ack),
    .Parallel_Data_Out(pdo_l), .Data_Valid_Out(v_l), .Overrun_Out(o_l),
    .Bit_Count_Out(cnt_l));

  function automatic logic [W-1:0] pack_word(input bit q[$], input bit msb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (msb) w[W-1-i] = q[i];
      else     w[i]     = q[i];
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Disabled data port must float; a 2-state simulator resolves it to 0.
  task automatic chk_off(input string name, input logic [W-1:0] act);
    n_cmp++;
    if (!(act === {W{1'bz}} || act === '0)) begin
      n_bad++;
      $display("FAIL %s: got %h expected zzzz at %0t", name, act, $time);
    end
  endtask

  // Model update from the inputs sampled at this rising edge.
  task automatic model_step();
    bit complete;
    complete = 1'b0;
    if (!rst) begin
      mq.delete();
      m_hold_m = '0; m_hold_l = '0; m_valid = 1'b0; m_ovr = 1'b0;
    end else if (en) begin
      if (clr) begin
        mq.delete();
        m_ovr = 1'b0;
      end else if (sh) begin
        mq.push_back(sd);
        if (mq.size() == W) begin
          m_hold_m = pack_word(mq, 1'b1);
          m_hold_l = pack_word(mq, 1'b0);
          mq.delete();
          complete = 1'b1;
        end
      end
      if (complete) begin
        if (m_valid && !ack) m_ovr = 1'b1;
        m_valid = 1'b1;
      end else if (ack) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic check_model();
    chk("cnt_m", 32'(cnt_m), 32'(mq.size()));
    chk("cnt_l", 32'(cnt_l), 32'(mq.size()));
    chk("valid_m", 32'(v_m), 32'(en & m_valid));
    chk("valid_l", 32'(v_l), 32'(en & m_valid));
    chk("ovr_m", 32'(o_m), 32'(m_ovr));
    chk("ovr_l", 32'(o_l), 32'(m_ovr));
    if (en) begin
      chk("data_m", 32'(pdo_m), 32'(m_hold_m));
      chk("data_l", 32'(pdo_l), 32'(m_hold_l));
    end else begin
      chk_off("data_m_off", pdo_m);
      chk_off("data_l_off", pdo_l);
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic s,
                       input logic h, input logic c, input logic a);
    rst = r; en = e; sd = s; sh = h; clr = c; ack = a;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int first, input int n,
                           input logic ack_last);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b1, w[first-i], 1'b1, 1'b0, (i == n-1) ? ack_last : 1'b0);
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic ack_last);
    send_bits(w, W-1, W, ack_last);
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; sd = 1'b0; sh = 1'b0; clr = 1'b0; ack = 1'b0;

    //            r     e     s     h     c     a     cnt   v     o
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};

    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].h, tbl[i].c, tbl[i].a);
      chk($sformatf("tbl%0d_cnt", i), 32'(cnt_m), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_valid", i), 32'(v_m), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_ovr", i), 32'(o_m), 32'(tbl[i].o));
    end

    // Full word after reset; valid rises on the 16th strobe.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(16'hA5C3, 15, 15, 1'b0);
    chk("a5c3_valid_early", 32'(v_m), 32'd0);
    chk("a5c3_cnt15", 32'(cnt_m), 32'd15);
    send_bits(16'hA5C3, 0, 1, 1'b0);
    chk("a5c3_data", 32'(pdo_m), 32'hA5C3);
    chk("a5c3_valid", 32'(v_m), 32'd1);
    chk("a5c3_cnt", 32'(cnt_m), 32'd0);
    chk("a5c3_ovr", 32'(o_m), 32'd0);

    // Overrun on unacknowledged word, cleared by clear pulse.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_word(16'h1234, 1'b0);
    send_word(16'hFFFF, 1'b0);
    chk("ovr_data", 32'(pdo_m), 32'hFFFF);
    chk("ovr_valid", 32'(v_m), 32'd1);
    chk("ovr_set", 32'(o_m), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_cleared", 32'(o_m), 32'd0);
    chk("ovr_valid_kept", 32'(v_m), 32'd1);

    // Ack coincident with completion: no overrun, valid stays high.
    send_word(16'h8001, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(16'h00FF, 1'b1);
    chk("ackcomp_data", 32'(pdo_m), 32'h00FF);
    chk("ackcomp_valid", 32'(v_m), 32'd1);
    chk("ackcomp_ovr", 32'(o_m), 32'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ack_drops_valid", 32'(v_m), 32'd0);
    chk("ack_keeps_data", 32'(pdo_m), 32'h00FF);

    // Clear with strobe mid-word drops the bit and resyncs.
    send_bits(16'h7F00, 15, 7, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_cnt", 32'(cnt_m), 32'd0);
    send_word(16'hBEEF, 1'b0);
    chk("beef_data", 32'(pdo_m), 32'hBEEF);

    // Disable mid-word: state frozen, outputs gated, resume on re-enable.
    send_bits(16'h5A3C, 15, 5, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'($urandom), 1'(i % 2), 1'(i == 3), 1'(i == 6));
    end
    chk("dis_cnt", 32'(cnt_m), 32'd5);
    chk("dis_valid", 32'(v_m), 32'd0);
    chk_off("dis_data", pdo_m);
    send_bits(16'h5A3C, 10, 11, 1'b0);
    chk("resume_data", 32'(pdo_m), 32'h5A3C);

    // Reset mid-word with a valid word held.
    send_bits(16'hFFFF, 15, 9, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_data", 32'(pdo_m), 32'd0);
    chk("rst_valid", 32'(v_m), 32'd0);
    chk("rst_ovr", 32'(o_m), 32'd0);
    chk("rst_cnt", 32'(cnt_m), 32'd0);

    // Bit order: first bit 1 then fifteen zeros.
    send_word(16'h8000, 1'b0);
    chk("lsb_first_data", 32'(pdo_l), 32'h0001);
    chk("msb_first_data", 32'(pdo_m), 32'h8000);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 199) != 0),
            1'($urandom_range(0, 9) != 0),
            1'($urandom),
            1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 49) == 0),
            1'($urandom_range(0, 9) < 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_in_parallel_out_sipo_16_bit.md
Name: serial_in_parallel_out_sipo_16_bit

Overview:
Serial-In-Parallel-Out (SIPO) deserializer. It collects DATA_WIDTH serial bits, strobed one per Shift_Data_Signal_In, into a parallel word. Each completed word is presented on a holding register with a valid/acknowledge handshake. It is the receive-side partner of the team's PISO shift register (MSB-first, one bit per shift strobe) and sits between a serial link and a parallel consumer.

Parameters:
DATA_WIDTH, 16, word width in bits (>= 2)
MSB_FIRST, 1, 1 = first received bit lands in bit DATA_WIDTH-1; 0 = first bit lands in bit 0

Ports:
Clk_In  input  1  clock; all flops update on rising edge
Reset_In  input  1  synchronous, active-low reset
Enable_In  input  1  block enable; low = hold all state, gate outputs
Serial_Data_In  input  1  serial data bit, sampled when shift strobe is high
Shift_Data_Signal_In  input  1  bit strobe; one bit captured per cycle it is high
Clear_Signal_In  input  1  abort partial word (frame resync)
Data_Ack_In  input  1  consumer accepts current held word
Parallel_Data_Out  output  DATA_WIDTH  last completed word; 'Z' when Enable_In low
Data_Valid_Out  output  1  held word not yet acknowledged; forced 0 when Enable_In low
Overrun_Out  output  1  sticky: a completed word overwrote an unacknowledged one
Bit_Count_Out  output  $clog2(DATA_WIDTH)  bits collected in current partial word

Behaviour:
- Internal state: shift register, bit counter, holding register, valid flag, overrun flag.
- Reset (Reset_In = 0 at rising edge):
  - all internal state cleared to 0.
  - Parallel_Data_Out = 0, Data_Valid_Out = 0, Overrun_Out = 0, Bit_Count_Out = 0.
  - Reset overrides every other input, including mid-word and mid-handshake.
- Enable_In = 0:
  - no state changes; strobes, clear and ack are ignored.
  - Parallel_Data_Out = 'Z', Data_Valid_Out = 0.
  - Overrun_Out and Bit_Count_Out still show the held state.
  - Re-enabling resumes exactly where the block stopped.
- Priority at each enabled edge: reset > Clear_Signal_In > Shift_Data_Signal_In.
  - Data_Ack_In is evaluated independently of these.
- Clear_Signal_In = 1:
  - shift register, counter and overrun flag are cleared.
  - holding register and valid flag are untouched.
  - any strobe in the same cycle is dropped.
- Shift strobe:
  - MSB_FIRST = 1: shift <= {shift[W-2:0], Serial_Data_In}.
  - MSB_FIRST = 0: shift <= {Serial_Data_In, shift[W-1:1]}.
  - counter increments by 1.
- Word completion (strobe while counter == W-1):
  - holding <= assembled word including the current bit.
  - counter wraps to 0; valid <= 1.
  - Latency: Parallel_Data_Out and Data_Valid_Out are updated at the same edge that captures the last bit.
- Handshake:
  - Data_Ack_In while valid = 1 clears valid at the next edge.
  - Ack while valid = 0 is ignored.
  - Parallel_Data_Out keeps its value after ack until the next completion.
- Completion and ack in the same cycle: the new word is loaded, valid stays 1, no overrun.
- Completion while valid = 1 and no ack:
  - the newest word overwrites holding; valid stays 1; overrun <= 1.
  - The overrun flag is cleared only by reset or Clear_Signal_In.
- Strobe back-to-back every cycle is supported: one word per W cycles, no bubble.
- Bit_Count_Out range is 0..W-1 and never reads W.

Test Plan:
- Reset then 16 consecutive strobes of 0xA5C3, MSB first -> Data_Valid_Out rises at edge 16, Parallel_Data_Out = 0xA5C3, Bit_Count_Out = 0, Overrun_Out = 0.
- Word 0x1234 complete, no ack, then word 0xFFFF complete -> Parallel_Data_Out = 0xFFFF, Data_Valid_Out = 1, Overrun_Out = 1. Clear_Signal_In pulse -> Overrun_Out = 0, Data_Valid_Out still 1.
- Data_Ack_In asserted on the same edge as the last bit of 0x00FF, while 0x8001 is pending -> Parallel_Data_Out = 0x00FF, Data_Valid_Out = 1, Overrun_Out = 0.
- 7 bits shifted, then Clear_Signal_In with a strobe in the same cycle -> Bit_Count_Out = 0. The next 16 bits of 0xBEEF yield exactly 0xBEEF.
- Enable_In dropped after 5 bits for 10 cycles with strobes toggling -> Parallel_Data_Out = 'Z', Data_Valid_Out = 0, Bit_Count_Out stays 5. Re-enable and 11 more bits complete the word correctly.
- Reset_In pulsed low after 9 bits with valid = 1 -> all outputs 0 at the next edge. MSB_FIRST = 0 instance receiving bits 1,0,0,... (15 zeros) -> Parallel_Data_Out = 0x0001.
